// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA data memory arbiter with starvation backstop; optional round-robin via DMEM_ARB_RR_EN
module dmem_arbiter #(
   parameter int AW       = 11,
   parameter int MAX_WAIT = 4
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_write,
   input  logic [7:0]    cpu_wdata,
   output logic          cpu_stall,
   output logic [7:0]    cpu_rdata,
   output logic          cpu_rvalid,
   input  logic          dma_req,
   input  logic [AW-1:0] dma_addr,
   input  logic          dma_write,
   input  logic [7:0]    dma_wdata,
   output logic          dma_gnt,
   output logic [7:0]    dma_rdata,
   output logic          dma_rvalid,
   output logic [AW-1:0] mem_addr,
   output logic          mem_write_en,
   output logic [7:0]    mem_di,
   input  logic [7:0]    mem_do
);

   typedef enum logic {NORMAL = 1'b0, FORCED = 1'b1} state_t;

   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT - 1);

   state_t     state_q;
   state_t     state_d;
   logic [3:0] wait_cnt;
   logic       dma_own;
   logic       cpu_gnt;
   logic       rd_cpu;
   logic       rd_dma;

`ifdef DMEM_ARB_RR_EN
   logic       rr_last;
`endif

   // Owner selection: FORCED or an idle CPU hands the bus to a requesting DMA
   always_comb begin
      dma_own = 1'b0;
      if (dma_req) begin
         if (state_q == FORCED) begin
            dma_own = 1'b1;
         end else if (!cpu_req) begin
            dma_own = 1'b1;
         end
`ifdef DMEM_ARB_RR_EN
         else if (!rr_last) begin
            dma_own = 1'b1;
         end
`endif
      end
   end

   // Memory port mux and handshakes; gated while reset is held so nothing leaks out
   always_comb begin
      cpu_gnt      = cpu_req & ~dma_own;
      dma_gnt      = RST_N & dma_own;
      cpu_stall    = RST_N & cpu_req & dma_own;
      mem_addr     = dma_own ? dma_addr  : cpu_addr;
      mem_di       = dma_own ? dma_wdata : cpu_wdata;
      mem_write_en = RST_N & (dma_own ? dma_write : (cpu_write & cpu_req));
      cpu_rdata    = mem_do;
      cpu_rvalid   = rd_cpu;
   end

   // Next state: force DMA after MAX_WAIT denials, FORCED lasts until granted or withdrawn
   always_comb begin
      state_d = state_q;
      case (state_q)
         NORMAL: begin
            if (dma_req && !dma_own && (wait_cnt == WAIT_LIM)) begin
               state_d = FORCED;
            end
         end
         FORCED: begin
            if (dma_own || !dma_req) begin
               state_d = NORMAL;
            end
         end
         default: state_d = NORMAL;
      endcase
   end

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= NORMAL;
      end else begin
         state_q <= state_d;
      end
   end

   // Starvation counter: counts denied DMA cycles, saturating
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wait_cnt <= 4'd0;
      end else if (!dma_req || dma_own) begin
         wait_cnt <= 4'd0;
      end else if (wait_cnt != 4'hF) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Read tags: remember who owns the data the memory returns next cycle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_cpu <= 1'b0;
         rd_dma <= 1'b0;
      end else begin
         rd_cpu <= cpu_gnt & ~cpu_write;
         rd_dma <= dma_own & ~dma_write;
      end
   end

   // DMA read data capture; held until the next DMA read returns
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         dma_rdata  <= 8'h00;
         dma_rvalid <= 1'b0;
      end else begin
         dma_rvalid <= rd_dma;
         if (rd_dma) begin
            dma_rdata <= mem_do;
         end
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Last winner of the bus; resets to DMA so the first contention goes to the CPU
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rr_last <= 1'b1;
      end else if (dma_own) begin
         rr_last <= 1'b1;
      end else if (cpu_gnt) begin
         rr_last <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a read-before-write memory model
module tb_dmem_arbiter;

   localparam int AW = 11;

   logic          CLK;
   logic          RST_N;
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic          cpu_write;
   logic [7:0]    cpu_wdata;
   logic          cpu_stall;
   logic [7:0]    cpu_rdata;
   logic          cpu_rvalid;
   logic          dma_req;
   logic [AW-1:0] dma_addr;
   logic          dma_write;
   logic [7:0]    dma_wdata;
   logic          dma_gnt;
   logic [7:0]    dma_rdata;
   logic          dma_rvalid;
   logic [AW-1:0] mem_addr;
   logic          mem_write_en;
   logic [7:0]    mem_di;
   logic [7:0]    mem_do;

   logic [7:0]    mem [0:(1<<AW)-1];

   int tests = 0;
   int fails = 0;

   dmem_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_write(dma_write), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_di(mem_di), .mem_do(mem_do)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Single-port synchronous memory, read-before-write
   always @(posedge CLK) begin
      if (mem_write_en) mem[mem_addr] <= mem_di;
      mem_do <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic cpu_wr(input logic [AW-1:0] a, input logic [7:0] d);
      cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = a; cpu_wdata = d;
      tick();
      cpu_req = 1'b0; cpu_write = 1'b0;
   endtask

   initial begin
      RST_N = 1'b0;
      cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 11'h010; cpu_wdata = 8'hEE;
      dma_req = 1'b1; dma_write = 1'b1; dma_addr = 11'h020; dma_wdata = 8'hDD;
      @(negedge CLK);
      check("rst_dma_gnt", dma_gnt, 0);
      check("rst_cpu_stall", cpu_stall, 0);
      check("rst_mem_we", mem_write_en, 0);
      check("rst_cpu_rvalid", cpu_rvalid, 0);
      check("rst_dma_rvalid", dma_rvalid, 0);
      check("rst_dma_rdata", dma_rdata, 0);
      cpu_req = 1'b0; cpu_write = 1'b0; dma_req = 1'b0; dma_write = 1'b0;
      tick(); tick();
      RST_N = 1'b1;

      // CPU write then read back with DMA idle
      cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 11'h010; cpu_wdata = 8'hA5;
      @(negedge CLK);
      check("cpuw_stall", cpu_stall, 0);
      check("cpuw_we", mem_write_en, 1);
      tick();
      cpu_write = 1'b0;
      @(negedge CLK);
      check("cpur_stall", cpu_stall, 0);
      check("cpur_we", mem_write_en, 0);
      tick();
      cpu_req = 1'b0;
      @(negedge CLK);
      check("cpur_rvalid", cpu_rvalid, 1);
      check("cpur_rdata", cpu_rdata, 8'hA5);
      tick();

      cpu_wr(11'h005, 8'h55);
      cpu_wr(11'h006, 8'h66);
      cpu_wr(11'h300, 8'h11);

      // DMA write then read with CPU idle
      dma_req = 1'b1; dma_write = 1'b1; dma_addr = 11'h200; dma_wdata = 8'h3C;
      @(negedge CLK);
      check("dmaw_gnt", dma_gnt, 1);
      check("dmaw_addr", mem_addr, 11'h200);
      tick();
      dma_write = 1'b0;
      @(negedge CLK);
      check("dmar_gnt", dma_gnt, 1);
      tick();
      dma_req = 1'b0;
      @(negedge CLK);
      check("dmar_rvalid_early", dma_rvalid, 0);
      tick();
      @(negedge CLK);
      check("dmar_rvalid", dma_rvalid, 1);
      check("dmar_rdata", dma_rdata, 8'h3C);
      tick();
      @(negedge CLK);
      check("dmar_rvalid_pulse", dma_rvalid, 0);
      check("dmar_rdata_hold", dma_rdata, 8'h3C);
      tick();

`ifndef DMEM_ARB_RR_EN
      // Starvation: CPU holds the bus, DMA forced in on the fifth cycle
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 11'h005;
      dma_req = 1'b1; dma_write = 1'b0; dma_addr = 11'h006;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check($sformatf("starve_gnt%0d", i), dma_gnt, 0);
         check($sformatf("starve_stall%0d", i), cpu_stall, 0);
         tick();
      end
      @(negedge CLK);
      check("forced_gnt", dma_gnt, 1);
      check("forced_stall", cpu_stall, 1);
      check("forced_addr", mem_addr, 11'h006);
      tick();
      dma_req = 1'b0;
      @(negedge CLK);
      check("after_forced_stall", cpu_stall, 0);
      check("after_forced_wait", dut.wait_cnt, 0);
      check("after_forced_state", dut.state_q, 0);
      tick();

      // CPU read of 0x005 followed by DMA read of 0x006: no cross-routing
      cpu_req = 1'b0;
      tick();
      cpu_req = 1'b1; cpu_addr = 11'h005;
      tick();
      cpu_req = 1'b0;
      dma_req = 1'b1; dma_write = 1'b0; dma_addr = 11'h006;
      @(negedge CLK);
      check("xr_cpu_rvalid", cpu_rvalid, 1);
      check("xr_cpu_rdata", cpu_rdata, 8'h55);
      check("xr_dma_gnt", dma_gnt, 1);
      tick();
      dma_req = 1'b0;
      @(negedge CLK);
      check("xr_cpu_rvalid_off", cpu_rvalid, 0);
      check("xr_dma_rvalid_early", dma_rvalid, 0);
      tick();
      @(negedge CLK);
      check("xr_dma_rvalid", dma_rvalid, 1);
      check("xr_dma_rdata", dma_rdata, 8'h66);
      tick();

      // Reset asserted while FORCED with a DMA write pending
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 11'h005;
      dma_req = 1'b1; dma_write = 1'b1; dma_addr = 11'h300; dma_wdata = 8'h77;
      repeat (4) tick();
      check("mid_forced_state", dut.state_q, 1);
      check("mid_forced_we", mem_write_en, 1);
      RST_N = 1'b0;
      #1;
      check("mid_rst_gnt", dma_gnt, 0);
      check("mid_rst_stall", cpu_stall, 0);
      check("mid_rst_we", mem_write_en, 0);
      cpu_req = 1'b0; dma_req = 1'b0; dma_write = 1'b0;
      tick(); tick();
      RST_N = 1'b1;
      check("post_rst_state", dut.state_q, 0);
      check("post_rst_wait", dut.wait_cnt, 0);
      cpu_req = 1'b1; cpu_addr = 11'h300;
      tick();
      cpu_req = 1'b0;
      @(negedge CLK);
      check("post_rst_rvalid", cpu_rvalid, 1);
      check("post_rst_mem", cpu_rdata, 8'h11);
      tick();
`else
      // Round-robin: continuous contention alternates CPU then DMA
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 11'h005;
      dma_req = 1'b1; dma_write = 1'b0; dma_addr = 11'h006;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         check($sformatf("rr_gnt%0d", i), dma_gnt, (i % 2));
         check($sformatf("rr_stall%0d", i), cpu_stall, (i % 2));
         tick();
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
